// File: rtl/s_machine_pkg.sv
// Shared S-Machine definitions: fetch state encoding, bus widths and the
// HALT opcode field.
package s_machine_pkg;

  localparam int ADDR_W = 8;
  localparam int INST_W = 16;
  localparam int CNT_W  = 16;

  // Opcode field location inside an instruction word.
  localparam int OPC_HI = 15;
  localparam int OPC_LO = 12;

  localparam logic [OPC_HI-OPC_LO:0] HALT_OPC = 4'b1000;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    ISSUE,
    HALT
  } fetch_state_t;

  // True when the instruction word carries the HALT opcode.
  function automatic logic is_halt_inst(input logic [INST_W-1:0] inst);
    return inst[OPC_HI:OPC_LO] == HALT_OPC;
  endfunction

endpackage

// File: rtl/inst_fetch_ctrl_if.sv
// Bundle of the fetch controller's memory, decode, redirect and status
// signals. master = fetch controller, slave = surrounding CPU.
interface inst_fetch_ctrl_if;
  import s_machine_pkg::*;

  logic              start;
  logic [ADDR_W-1:0] mem_addr;
  logic [INST_W-1:0] mem_inst;
  logic [INST_W-1:0] inst_out;
  logic [ADDR_W-1:0] inst_pc;
  logic              inst_valid;
  logic              inst_ready;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_target;
  logic              halted;
  logic              busy;
  logic [CNT_W-1:0]  issue_count;

  modport master (
    input  start, mem_inst, inst_ready, redirect_valid, redirect_target,
    output mem_addr, inst_out, inst_pc, inst_valid, halted, busy, issue_count
  );

  modport slave (
    output start, mem_inst, inst_ready, redirect_valid, redirect_target,
    input  mem_addr, inst_out, inst_pc, inst_valid, halted, busy, issue_count
  );

endinterface

// File: rtl/inst_fetch_ctrl.sv
// Instruction fetch sequencer: owns the PC, latches each instruction from
// the combinational instruction memory, offers it to decode over
// valid/ready, follows execute redirects and stops on HALT.
module inst_fetch_ctrl
  import s_machine_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input logic              clk,
  input logic              reset,
  inst_fetch_ctrl_if.master bus
);

  fetch_state_t      state;
  fetch_state_t      state_next;
  logic [ADDR_W-1:0] pc;
  logic              is_halt;
  logic              handshake;
  logic              redirect;

  assign handshake = bus.inst_valid && bus.inst_ready;
  assign redirect  = bus.redirect_valid;

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignment so every register
    // samples the pre-edge values regardless of process ordering.
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state decision; redirect beats handshake and HALT.
  always_comb begin
    // NOTE: default first so no path leaves state_next unassigned (no latch).
    state_next = state;
    case (state)
      IDLE:  if (bus.start) state_next = FETCH;
      FETCH: state_next = redirect ? FETCH : ISSUE;
      ISSUE: begin
        if (redirect)       state_next = FETCH;
        else if (handshake) state_next = is_halt ? HALT : FETCH;
      end
      HALT:  state_next = HALT;
      default: state_next = IDLE;
    endcase
  end

  // Status outputs decoded from state; memory address is the live PC.
  always_comb begin
    bus.busy     = (state == FETCH) || (state == ISSUE);
    bus.halted   = (state == HALT);
    bus.mem_addr = pc;
  end

  // Datapath: PC, instruction register, valid flag, HALT flag, counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc              <= RESET_PC;
      bus.inst_out    <= '0;
      bus.inst_pc     <= '0;
      bus.inst_valid  <= 1'b0;
      bus.issue_count <= '0;
      is_halt         <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (redirect) pc <= bus.redirect_target;
        end
        FETCH: begin
          if (redirect) begin
            // Capture discarded: instruction register keeps its old word.
            pc             <= bus.redirect_target;
            is_halt        <= 1'b0;
            bus.inst_valid <= 1'b0;
          end else begin
            bus.inst_out   <= bus.mem_inst;
            bus.inst_pc    <= pc;
            pc             <= pc + ADDR_W'(1);
            bus.inst_valid <= 1'b1;
            is_halt        <= is_halt_inst(bus.mem_inst);
          end
        end
        ISSUE: begin
          if (handshake) begin
            bus.inst_valid <= 1'b0;
            if (bus.issue_count != '1)
              bus.issue_count <= bus.issue_count + CNT_W'(1);
          end
          if (redirect) begin
            pc             <= bus.redirect_target;
            bus.inst_valid <= 1'b0;
          end
        end
        default: ;  // HALT: everything frozen until reset
      endcase
    end
  end

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Self-checking bench for inst_fetch_ctrl: a behavioural fetch model is
// compared against the DUT every cycle, and directed scenarios check the
// issued instruction stream against hand-computed values.
module tb_inst_fetch_ctrl;

  logic clk = 1'b0;
  logic reset;

  inst_fetch_ctrl_if bus ();

  inst_fetch_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Instruction memory beside the controller, combinational read.
  logic [15:0] mem [256];
  assign bus.mem_inst = mem[bus.mem_addr];

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // m_busy: fetching has been started; m_valid: a word is on offer.
  logic [7:0]  m_pc, m_ipc;
  logic [15:0] m_inst, m_cnt;
  bit          m_busy, m_valid, m_halted, model_ok = 0;

  always @(posedge clk) begin
    if (reset) begin
      m_pc = 8'h00; m_ipc = 8'h00; m_inst = 16'h0000; m_cnt = 16'h0000;
      m_busy = 0; m_valid = 0; m_halted = 0; model_ok = 1;
    end else if (m_halted) begin
      // frozen until reset
    end else if (!m_busy) begin
      if (bus.redirect_valid) m_pc = bus.redirect_target;
      if (bus.start) m_busy = 1;
    end else if (!m_valid) begin
      if (bus.redirect_valid) m_pc = bus.redirect_target;
      else begin
        m_inst = mem[m_pc]; m_ipc = m_pc; m_pc = m_pc + 8'd1; m_valid = 1;
      end
    end else begin
      if (bus.inst_ready) begin
        if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
        m_valid = 0;
      end
      if (bus.redirect_valid) begin
        m_pc = bus.redirect_target; m_valid = 0;
      end else if (bus.inst_ready && m_inst[15:12] == 4'b1000) begin
        m_halted = 1; m_busy = 0;
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (model_ok) begin
      check("cyc_mem_addr",    32'(bus.mem_addr),    32'(m_pc));
      check("cyc_inst_valid",  32'(bus.inst_valid),  32'(m_valid));
      check("cyc_inst_out",    32'(bus.inst_out),    32'(m_inst));
      check("cyc_inst_pc",     32'(bus.inst_pc),     32'(m_ipc));
      check("cyc_halted",      32'(bus.halted),      32'(m_halted));
      check("cyc_busy",        32'(bus.busy),        32'(m_busy));
      check("cyc_issue_count", 32'(bus.issue_count), 32'(m_cnt));
    end
  end

  // Log of observed transfers {inst_pc, inst_out}.
  logic [23:0] xfer_log [$];
  always @(negedge clk) begin
    if (!reset && bus.inst_valid && bus.inst_ready)
      xfer_log.push_back({bus.inst_pc, bus.inst_out});
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.start = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_target = 8'h00;
    tick(2);
    reset = 1'b0;
    xfer_log.delete();
  endtask

  task automatic start_pulse();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic wait_valid_pc(input logic [7:0] p, input string nm);
    int n = 0;
    while (!(bus.inst_valid && bus.inst_pc == p) && n < 60) begin
      tick();
      n++;
    end
    check(nm, 32'(n < 60), 32'd1);
  endtask

  task automatic wait_halted(input string nm);
    int n = 0;
    while (!bus.halted && n < 100) begin
      tick();
      n++;
    end
    check(nm, 32'(n < 100), 32'd1);
  endtask

  logic [15:0] prog [8];

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    prog[0] = 16'h0401; prog[1] = 16'h0C01; prog[2] = 16'h4000; prog[3] = 16'h5000;
    prog[4] = 16'h2801; prog[5] = 16'h6000; prog[6] = 16'h7000; prog[7] = 16'h8000;
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    for (int i = 0; i < 8; i++) mem[i] = prog[i];
    mem[255] = 16'h1234;
    bus.inst_ready = 1'b0;

    // 1: full program run to HALT.
    do_reset();
    check("rst_valid", 32'(bus.inst_valid), 32'd0);
    check("rst_addr",  32'(bus.mem_addr),   32'd0);
    check("rst_busy",  32'(bus.busy),       32'd0);
    check("rst_count", 32'(bus.issue_count), 32'd0);
    bus.inst_ready = 1'b1;
    start_pulse();
    check("first_not_yet_valid", 32'(bus.inst_valid), 32'd0);
    tick();
    check("first_valid_latency", 32'(bus.inst_valid), 32'd1);
    wait_halted("t1_halt_reached");
    check("t1_log_size", 32'(xfer_log.size()), 32'd8);
    for (int i = 0; i < 8 && i < xfer_log.size(); i++) begin
      check("t1_pc",   32'(xfer_log[i][23:16]), 32'(i));
      check("t1_inst", 32'(xfer_log[i][15:0]),  32'(prog[i]));
    end
    check("t1_count", 32'(bus.issue_count), 32'd8);
    check("t1_pc_frozen", 32'(bus.mem_addr), 32'd8);
    bus.start = 1'b1; bus.redirect_valid = 1'b1; bus.redirect_target = 8'h03;
    tick(3);
    bus.start = 1'b0; bus.redirect_valid = 1'b0;
    check("t1_halt_ignores_in", 32'(bus.mem_addr), 32'd8);
    check("t1_still_halted",    32'(bus.halted),   32'd1);

    // 2: decode stall while offering PC 2.
    do_reset();
    bus.inst_ready = 1'b1;
    start_pulse();
    wait_valid_pc(8'd2, "t2_reach_pc2");
    bus.inst_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t2_hold_inst",  32'(bus.inst_out),    32'h4000);
      check("t2_hold_pc",    32'(bus.inst_pc),     32'd2);
      check("t2_hold_valid", 32'(bus.inst_valid),  32'd1);
      check("t2_hold_count", 32'(bus.issue_count), 32'd2);
    end
    bus.inst_ready = 1'b1;
    tick();
    check("t2_resume_count", 32'(bus.issue_count), 32'd3);
    wait_valid_pc(8'd3, "t2_next_pc3");

    // 3: redirect coinciding with the handshake of PC 1.
    do_reset();
    bus.inst_ready = 1'b1;
    start_pulse();
    wait_valid_pc(8'd1, "t3_reach_pc1");
    bus.redirect_valid = 1'b1; bus.redirect_target = 8'h05;
    tick();
    bus.redirect_valid = 1'b0;
    check("t3_count_after", 32'(bus.issue_count), 32'd2);
    wait_valid_pc(8'd5, "t3_reach_pc5");
    check("t3_inst5", 32'(bus.inst_out), 32'h6000);
    tick();
    check("t3_log_size", 32'(xfer_log.size()), 32'd3);
    if (xfer_log.size() >= 3) begin
      check("t3_log1",     32'(xfer_log[1]), 32'h010C01);
      check("t3_log2_pc5", 32'(xfer_log[2]), 32'h056000);
    end

    // 4: redirect to 0xFF with wrap-around of the PC.
    do_reset();
    bus.inst_ready = 1'b1;
    bus.redirect_valid = 1'b1; bus.redirect_target = 8'hFF;
    start_pulse();
    bus.redirect_valid = 1'b0;
    tick();
    check("t4_pc_ff",    32'(bus.inst_pc),  32'hFF);
    check("t4_inst_ff",  32'(bus.inst_out), 32'h1234);
    check("t4_addr_wrap", 32'(bus.mem_addr), 32'h00);
    tick(2);
    check("t4_pc_00",   32'(bus.inst_pc),  32'h00);
    check("t4_inst_00", 32'(bus.inst_out), 32'h0401);

    // 5: redirect during the fetch of the HALT word.
    do_reset();
    bus.inst_ready = 1'b1;
    start_pulse();
    wait_valid_pc(8'd6, "t5_reach_pc6");
    tick();
    check("t5_fetching_7", 32'(bus.mem_addr), 32'd7);
    bus.redirect_valid = 1'b1; bus.redirect_target = 8'h00;
    tick();
    bus.redirect_valid = 1'b0;
    tick();
    check("t5_valid",   32'(bus.inst_valid), 32'd1);
    check("t5_pc0",     32'(bus.inst_pc),    32'd0);
    check("t5_inst0",   32'(bus.inst_out),   32'h0401);
    tick(3);
    check("t5_not_halted", 32'(bus.halted), 32'd0);

    // 6: reset during ISSUE and during HALT.
    do_reset();
    bus.inst_ready = 1'b0;
    start_pulse();
    tick();
    check("t6_in_issue", 32'(bus.inst_valid), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("t6_rst_valid", 32'(bus.inst_valid), 32'd0);
    check("t6_rst_out",   32'(bus.inst_out),   32'd0);
    check("t6_rst_ipc",   32'(bus.inst_pc),    32'd0);
    check("t6_rst_busy",  32'(bus.busy),       32'd0);
    tick(4);
    check("t6_needs_start", 32'(bus.inst_valid), 32'd0);
    bus.inst_ready = 1'b1;
    start_pulse();
    wait_halted("t6_halt_reached");
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("t6_halt_rst_halted", 32'(bus.halted),      32'd0);
    check("t6_halt_rst_addr",   32'(bus.mem_addr),    32'd0);
    check("t6_halt_rst_count",  32'(bus.issue_count), 32'd0);
    tick(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/inst_fetch_ctrl.md
Name: inst_fetch_ctrl

Overview:
Fetch sequencer for the S-Machine instruction memory (InstMemory: 8-bit PC in, 16-bit inst out, combinational read).
- Owns the program counter and drives the memory address.
- Latches each instruction into an instruction register and offers it to decode over a valid/ready handshake.
- Handles branch redirects from execute and stops fetching on the HALT opcode.

Parameters:
ADDR_W, 8, program counter / memory address width
INST_W, 16, instruction width
RESET_PC, 0, PC value loaded on reset
HALT_OPC, 4'b1000, value of inst[15:12] that marks HALT
CNT_W, 16, width of retired-instruction counter

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
start  in  1  begin fetching from current PC (sampled in IDLE only)
mem_addr  out  ADDR_W  address to InstMemory PC input; equals internal PC
mem_inst  in  INST_W  InstMemory inst output, valid same cycle as mem_addr
inst_out  out  INST_W  registered instruction to decode
inst_pc  out  ADDR_W  address inst_out was fetched from
inst_valid  out  1  inst_out/inst_pc valid
inst_ready  in  1  decode accepts; transfer when inst_valid && inst_ready
redirect_valid  in  1  branch/jump taken, 1-cycle pulse
redirect_target  in  ADDR_W  new PC
halted  out  1  HALT retired; fetch stopped
busy  out  1  state is FETCH or ISSUE
issue_count  out  CNT_W  number of handshakes completed, saturating

Behaviour:
Reset (synchronous, active-high):
- state=IDLE, PC=RESET_PC, inst_out=0, inst_pc=0, inst_valid=0, halted=0, issue_count=0.
- Reset dominates all inputs, including mid-ISSUE and during HALT.

States: IDLE, FETCH, ISSUE, HALT.
- IDLE: start=1 -> FETCH. Otherwise hold. redirect_valid=1 in IDLE loads PC=redirect_target and stays in IDLE.
- FETCH (1 cycle):
  - inst_out<=mem_inst, inst_pc<=PC, PC<=PC+1 (modulo 2^ADDR_W; 255 wraps to 0).
  - inst_valid<=1, next state ISSUE.
  - The is_halt flag is registered as (mem_inst[15:12]==HALT_OPC).
- ISSUE:
  - inst_valid=1. inst_out and inst_pc stay stable until handshake.
  - On handshake: inst_valid<=0 and issue_count increments, saturating at all-ones.
  - After handshake, next state is HALT if is_halt, else FETCH.
  - No handshake: remain in ISSUE.
- HALT: halted=1, inst_valid=0, PC frozen; start and redirect are ignored. Exit only by reset.

Redirect (redirect_valid=1) in FETCH or ISSUE:
- PC<=redirect_target, next state FETCH, inst_valid<=0.
- In FETCH, the capture is discarded: inst_out is not updated and is_halt is cleared.
- In ISSUE with a simultaneous handshake:
  - The transfer counts and issue_count increments.
  - Redirect still wins the PC and next state, including over is_halt.
- In ISSUE without a handshake, the pending instruction is dropped and not counted.

General timing and outputs:
- Throughput: 1 instruction per 2 cycles when inst_ready is held high.
- First inst_valid appears 2 cycles after the start cycle.
- mem_addr = PC, combinational from the register.
- busy = (state==FETCH || state==ISSUE).

Decomposition:
Shared package s_machine_pkg holds:
- fetch_state_t enum (IDLE, FETCH, ISSUE, HALT)
- ADDR_W / INST_W constants
- HALT_OPC and the opcode field position [15:12]

No sub-module is needed. InstMemory is instantiated beside this block at CPU top level, not inside it.

Test Plan:
1. Load memory[0..7] with the standard 8-word program ending 16'b1000_0000_0000_0000; reset, start, inst_ready=1.
   -> inst_out sequence 0x0401, 0x0C01, 0x4000, 0x5000, 0x2801, 0x6000, 0x7000, 0x8000 with inst_pc 0..7.
   -> halted=1 the cycle after the HALT handshake; issue_count=8; PC=8 frozen.
2. inst_ready=0 for 5 cycles while in ISSUE at PC 2.
   -> inst_out stays 0x4000, inst_pc stays 2, inst_valid stays 1, issue_count unchanged; resumes on ready.
3. redirect_valid=1, target=0x05, in the same cycle as the handshake of inst_pc=1.
   -> issue_count increments; next inst_pc=5, inst_out=0x6000; PC 2..4 never issued.
4. Redirect to 0xFF holding 0x1234, memory[0] non-HALT.
   -> issues inst_pc=0xFF, then inst_pc=0x00 (wrap-around).
5. redirect_valid during FETCH of the HALT word (PC 7), target=0.
   -> HALT not issued, halted stays 0, next inst_pc=0.
6. Assert reset during ISSUE and again while in HALT.
   -> next cycle all outputs at reset values, state IDLE; start required before any inst_valid.
